fpu_dispatcher: RTL and testbench
=================================

// Module: fpu_dispatcher
// PURPOSE
//  Initiator side of the FPU start/done interface.
//  Accepts tagged FP commands on a valid/ready port and buffers them in a command FIFO.
//  Issues commands one at a time to pipelined_fpu (start/op/a/b), waiting on busy/done.
//  Returns each result with its tag on a valid/ready response port.
//  A watchdog converts a hung operation into an error response.
// PARAMETERS
//  DEPTH    4    command FIFO entries; power of 2, >=2
//  TAG_W    4    request/response tag width
//  TIMEOUT  64   max cycles from fpu_start to fpu_done before abort; >=2
// PORTS
//  clk          in   1      single clock, all state rising-edge
//  reset        in   1      synchronous, active-high
//  req_valid    in   1      command present
//  req_ready    out  1      FIFO can accept (count < DEPTH)
//  req_op       in   3      FPU op code, passed through unchanged
//  req_a        in   32     operand a, IEEE-754 single
//  req_b        in   32     operand b, IEEE-754 single
//  req_tag      in   TAG_W  returned with the result
//  fpu_start    out  1      one-cycle start pulse to FPU
//  fpu_op       out  3      op to FPU
//  fpu_a        out  32     operand a to FPU
//  fpu_b        out  32     operand b to FPU
//  fpu_busy     in   1      FPU multi-cycle op in progress
//  fpu_done     in   1      FPU result valid (single-cycle pulse)
//  fpu_result   in   32     FPU result, sampled when fpu_done=1
//  rsp_valid    out  1      response held
//  rsp_ready    in   1      consumer accepts response
//  rsp_result   out  32     result, or 32'h7FC0_0000 on timeout
//  rsp_tag      out  TAG_W  tag of the completed command
//  rsp_error    out  1      1 = watchdog timeout
// BEHAVIOUR
//  Reset: FIFO empty, FSM=IDLE, watchdog=0.
//  Reset: req_ready=0 during reset, 1 the cycle after.
//  Reset: fpu_start=0, fpu_op/a/b=0, rsp_valid=0, rsp_result/tag/error=0.
//  Reset mid-operation aborts silently: no response, in-flight command lost.
//  Request: push when req_valid & req_ready.
//  Request: req_ready = (count != DEPTH), registered-state only, no comb path from pops.
//  Request: push and pop in the same cycle are both honoured; count unchanged.
//  Request: the full-cycle push is refused even if a pop occurs that cycle.
//  FSM IDLE: FIFO non-empty -> pop head into op/a/b/tag holding regs -> ISSUE.
//  FSM ISSUE: fpu_start=1 iff fpu_busy=0, else stall in ISSUE with start low.
//  FSM ISSUE: with start=1, go to WAIT, or direct to HOLD if fpu_done in the same cycle.
//  FSM ISSUE: a same-cycle fpu_done covers single-cycle ops.
//  FSM WAIT: watchdog increments every cycle.
//  FSM WAIT: on fpu_done, capture fpu_result, error=0 -> HOLD.
//  FSM WAIT: on watchdog == TIMEOUT-1 with no done, result=qNaN, error=1 -> HOLD.
//  FSM WAIT: fpu_done in the timeout cycle wins; error=0.
//  FSM HOLD: rsp_valid=1 with result/tag/error stable until rsp_valid & rsp_ready.
//  FSM HOLD: then clear watchdog; next state IDLE.
//  fpu_op/a/b stay stable from the start cycle through the done cycle (FPU datapath is combinational on them).
//  fpu_start never asserts outside ISSUE; at most one command in flight.
//  fpu_done outside ISSUE/WAIT (stale after timeout) is ignored.
//  Latency: req accepted cycle N -> fpu_start earliest N+2.
//  Latency: done at cycle D -> rsp_valid at D+1.
//  Throughput: one command per (FPU latency + 3) cycles with rsp_ready=1.
//  Ordering: responses strictly in request order.
// STRUCTURE
//  Package fpu_dispatch_pkg: typedef enum {IDLE, ISSUE, WAIT, HOLD} dispatch_state.
//  Package fpu_dispatch_pkg: localparam QNAN = 32'h7FC0_0000; cmd_t struct {op, a, b, tag}.
//  Sub-module fpu_cmd_fifo: sync FIFO of cmd_t, DEPTH entries.
//  fpu_cmd_fifo: wrap-around pointers with extra bit, full/empty/count.
//  Top holds FSM, holding regs, watchdog and response register.
// TESTING
//  ADD 3F80_0000 + 4000_0000, tag 5 -> fpu_start once.
//  ADD expect -> rsp_result 4040_0000, tag 5, error 0.
//  Divide 4120_0000 / 4000_0000 -> fpu_busy held.
//  Divide expect -> start low while busy; fpu_op/a/b stable until done; rsp 40A0_0000.
//  Push DEPTH+1 back-to-back with rsp_ready=0 -> req_ready drops after DEPTH+1 accepted.
//  Push expect -> DEPTH queued + 1 in flight; drain returns tags in order.
//  FPU model never asserts done -> after TIMEOUT cycles rsp 7FC0_0000, error 1.
//  Timeout expect -> the next command issues normally.
//  Reset asserted in WAIT and in HOLD -> all outputs 0 next cycle; no response emitted.
//  Simultaneous push and pop at count=DEPTH-1 -> count unchanged, req_ready stays 1.

Source files
------------

// File: rtl/fpu_dispatch_pkg.sv
// Shared types for the FPU dispatcher: FSM states, the queued command record, qNaN constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_dispatch_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} dispatch_state;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // The tag field is sized for the widest tag any instance may use; narrower
  // instances zero-extend on the way in and slice on the way out.
  localparam int TAG_W_MAX = 16;

  typedef struct packed {
    logic [2:0]           op;
    logic [31:0]          a;
    logic [31:0]          b;
    logic [TAG_W_MAX-1:0] tag;
  } cmd_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous FIFO of cmd_t entries with wrap-around pointers (one extra pointer bit).
// Latency: a write is visible at the head on the cycle after it is accepted.
// Backpressure: writes while full are dropped; the parent gates wr_vld with its own ready.
//
// Ports: clk, reset (sync, active-high); wr_vld/wr_dat push side;
//        rd_vld (non-empty), rd_rdy (pop), rd_dat (head, combinational); count.
module fpu_cmd_fifo
  import fpu_dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_vld,
  input  cmd_t                       wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output cmd_t                       rd_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        do_wr;
  logic        do_rd;

  // Pointer difference is exact thanks to the extra wrap bit.
  assign count  = wr_ptr - rd_ptr;
  assign full   = (count == FULL_CNT);
  assign rd_vld = (wr_ptr != rd_ptr);
  assign rd_dat = mem[rd_ptr[AW-1:0]];
  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_rdy && rd_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/fpu_dispatcher.sv
// Queues tagged FP commands and runs them one at a time on the FPU start/done port, with a watchdog.
// Latency: accept at N -> fpu_start at N+2 earliest; fpu_done at D -> rsp_valid at D+1.
// Backpressure: req_ready drops when the FIFO is full; the response is held until rsp_ready.
//
// Ports: clk, reset (sync, active-high)
//        req_valid/req_ready/req_op/req_a/req_b/req_tag   command input
//        fpu_start/fpu_op/fpu_a/fpu_b, fpu_busy/fpu_done/fpu_result   FPU start/done port
//        rsp_valid/rsp_ready/rsp_result/rsp_tag/rsp_error  response output
module fpu_dispatcher
  import fpu_dispatch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,   // must not exceed TAG_W_MAX
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             fpu_start,
  output logic [2:0]       fpu_op,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic             fpu_busy,
  input  logic             fpu_done,
  input  logic [31:0]      fpu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_error
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WDOG_ONE  = WW'(1);

  dispatch_state state_q, state_d;
  cmd_t          wr_cmd;
  cmd_t          head_cmd;
  cmd_t          hold_q;
  logic          fifo_vld;
  logic          fifo_pop;
  logic [CW-1:0] fifo_cnt;
  logic [WW-1:0] wdog_q;
  logic          rsp_load;
  logic [31:0]   rsp_result_d;
  logic          rsp_error_d;
  logic          unused_tag_bits;

  // Ready depends only on the registered count (and reset), never on this
  // cycle's pop, so a full FIFO refuses a push even while it is being drained.
  assign req_ready = !reset && (fifo_cnt != FULL_CNT);

  always_comb begin
    wr_cmd     = '0;
    wr_cmd.op  = req_op;
    wr_cmd.a   = req_a;
    wr_cmd.b   = req_b;
    wr_cmd.tag = TAG_W_MAX'(req_tag);
  end

  fpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (req_valid && req_ready),
    .wr_dat (wr_cmd),
    .rd_vld (fifo_vld),
    .rd_rdy (fifo_pop),
    .rd_dat (head_cmd),
    .count  (fifo_cnt)
  );

  // Operands come straight from the holding register, which only changes on
  // a pop in IDLE, so they stay stable from start through done.
  assign fpu_op    = hold_q.op;
  assign fpu_a     = hold_q.a;
  assign fpu_b     = hold_q.b;
  assign rsp_valid = (state_q == HOLD);

  // Upper tag bits are padding when TAG_W < TAG_W_MAX.
  assign unused_tag_bits = ^hold_q.tag;

  always_comb begin
    state_d      = state_q;
    fpu_start    = 1'b0;
    fifo_pop     = 1'b0;
    rsp_load     = 1'b0;
    rsp_result_d = fpu_result;
    rsp_error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_vld) begin
          fifo_pop = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // fpu_done seen here only counts when paired with our own start;
        // a single-cycle op completes in the start cycle.
        if (!fpu_busy) begin
          fpu_start = 1'b1;
          if (fpu_done) begin
            rsp_load = 1'b1;
            state_d  = HOLD;
          end else begin
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        // done takes priority over an expiring watchdog in the same cycle
        if (fpu_done) begin
          rsp_load = 1'b1;
          state_d  = HOLD;
        end else if (wdog_q == WDOG_LAST) begin
          rsp_load     = 1'b1;
          rsp_result_d = QNAN;
          rsp_error_d  = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      wdog_q     <= '0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_error  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) hold_q <= head_cmd;
      if (state_q == WAIT)                   wdog_q <= wdog_q + WDOG_ONE;
      else if (state_q == HOLD && rsp_ready) wdog_q <= '0;
      if (rsp_load) begin
        rsp_result <= rsp_result_d;
        rsp_tag    <= hold_q.tag[TAG_W-1:0];
        rsp_error  <= rsp_error_d;
      end
    end
  end

endmodule

// File: tb/tb_fpu_dispatcher.sv
// Scoreboard bench for fpu_dispatcher with a behavioural FPU (configurable latency / hang / forced busy).
// Latency: n/a.
// Backpressure: rsp_ready driven per test to build up and drain the command FIFO.
module tb_fpu_dispatcher;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             fpu_start;
  logic [2:0]       fpu_op;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic             fpu_busy;
  logic             fpu_done;
  logic [31:0]      fpu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_error;

  fpu_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .fpu_start  (fpu_start),
    .fpu_op     (fpu_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_busy   (fpu_busy),
    .fpu_done   (fpu_done),
    .fpu_result (fpu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_error  (rsp_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural FPU ----------------
  int lat_cfg    = 1;      // 0: done in the start cycle
  bit hang_cfg   = 1'b0;   // never raise done
  bit busy_force = 1'b0;
  int fcnt;

  function automatic logic [31:0] fp_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (op == OP_ADD && a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4080_0000;
    if (op == OP_SUB && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    if (op == OP_MUL && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (op == OP_MUL && a == 32'h3F80_0000 && b == 32'h3F80_0000) return 32'h3F80_0000;
    if (op == OP_DIV && a == 32'h4120_0000 && b == 32'h4000_0000) return 32'h40A0_0000;
    return 32'hFFFF_FFFF;
  endfunction

  always @(posedge clk) begin
    if (reset)                          fcnt <= 0;
    else if (fpu_start && lat_cfg > 0)  fcnt <= lat_cfg;
    else if (fcnt > 0)                  fcnt <= fcnt - 1;
  end

  assign fpu_done   = hang_cfg ? 1'b0 : (lat_cfg == 0) ? fpu_start : (fcnt == 1);
  assign fpu_busy   = busy_force || (fcnt > 1);
  assign fpu_result = fp_model(fpu_op, fpu_a, fpu_b);

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t       exp_q[$];
  int         start_cnt = 0;
  int         start_cyc = 0;
  int         rsp_cyc   = 0;
  int         acc_cyc   = 0;
  bit         inflight  = 1'b0;
  bit         prev_rv   = 1'b0;
  logic [66:0] cap_opnd;

  always @(negedge clk) begin
    if (reset) begin
      inflight = 1'b0;
      prev_rv  = 1'b0;
    end else begin
      if (fpu_start) begin
        start_cnt++;
        start_cyc = cyc;
        chk("start_while_busy", fpu_busy, 1'b0);
        inflight = !fpu_done;
        cap_opnd = {fpu_op, fpu_a, fpu_b};
      end else if (fpu_done && inflight) begin
        chk("operands_stable", {fpu_op, fpu_a, fpu_b}, cap_opnd);
        inflight = 1'b0;
      end
      if (rsp_valid && !prev_rv) rsp_cyc = cyc;
      prev_rv = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual tag=%0h result=%0h required none", rsp_tag, rsp_result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_tag",    rsp_tag,    e.tag);
          chk("rsp_error",  rsp_error,  e.err);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic err,
                      input bit want);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", req_ready, 1'b1);
    if (req_ready) begin
      acc_cyc = cyc;
      if (want) exp_q.push_back('{res, tag, err});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {fpu_start, fpu_op, fpu_a, fpu_b, rsp_valid, rsp_result, rsp_tag, rsp_error, req_ready}, '0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    int n;
    int s0;
    int a1;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_outputs");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1'b1);
    @(posedge clk);
    #1;

    // single-cycle ADD: done arrives in the start cycle
    lat_cfg = 0;
    s0 = start_cnt;
    send(OP_ADD, 32'h3F80_0000, 32'h4000_0000, 4'd5, 32'h4040_0000, 1'b0, 1'b1);
    drain();
    chk("add_one_start", start_cnt - s0, 1);
    chk("add_accept_to_start", start_cyc - acc_cyc, 2);
    chk("add_done_to_rsp", rsp_cyc - start_cyc, 1);

    // multi-cycle DIV held off by fpu_busy
    lat_cfg    = 4;
    busy_force = 1'b1;
    s0 = start_cnt;
    send(OP_DIV, 32'h4120_0000, 32'h4000_0000, 4'd6, 32'h40A0_0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("start_low_while_busy", fpu_start, 1'b0);
    end
    @(posedge clk);
    #1;
    busy_force = 1'b0;
    drain();
    chk("div_one_start", start_cnt - s0, 1);
    chk("div_done_to_rsp", rsp_cyc - start_cyc, 5);

    // fill: DEPTH queued + 1 in flight, then further pushes refused
    lat_cfg   = 1;
    rsp_ready = 1'b0;
    send(OP_MUL, 32'h3F80_0000, 32'h3F80_0000, 4'd1, 32'h3F80_0000, 1'b0, 1'b1);
    a1 = acc_cyc;
    send(OP_ADD, 32'h4000_0000, 32'h4000_0000, 4'd2, 32'h4080_0000, 1'b0, 1'b1);
    send(OP_SUB, 32'h4040_0000, 32'h3F80_0000, 4'd3, 32'h4000_0000, 1'b0, 1'b1);
    send(OP_MUL, 32'h4000_0000, 32'h4040_0000, 4'd4, 32'h40C0_0000, 1'b0, 1'b1);
    send(OP_DIV, 32'h4120_0000, 32'h4000_0000, 4'd5, 32'h40A0_0000, 1'b0, 1'b1);
    chk("fill_back_to_back", acc_cyc - a1, 4);
    req_valid = 1'b1;
    req_op    = OP_ADD;
    req_a     = 32'h3F80_0000;
    req_b     = 32'h4000_0000;
    req_tag   = 4'd15;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_ready_low", req_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // push and pop in the same cycle at count = DEPTH-1
    rsp_ready = 1'b0;
    send(OP_MUL, 32'h3F80_0000, 32'h3F80_0000, 4'd8,  32'h3F80_0000, 1'b0, 1'b1);
    send(OP_ADD, 32'h4000_0000, 32'h4000_0000, 4'd9,  32'h4080_0000, 1'b0, 1'b1);
    send(OP_SUB, 32'h4040_0000, 32'h3F80_0000, 4'd10, 32'h4000_0000, 1'b0, 1'b1);
    send(OP_MUL, 32'h4000_0000, 32'h4040_0000, 4'd11, 32'h40C0_0000, 1'b0, 1'b1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pp_hold_reached", rsp_valid, 1'b1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);            // response handshake; IDLE pops next edge
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = OP_ADD;
    req_a     = 32'h3F80_0000;
    req_b     = 32'h4000_0000;
    req_tag   = 4'd12;
    @(negedge clk);
    chk("pp_ready_before", req_ready, 1'b1);
    if (req_ready) exp_q.push_back('{32'h4040_0000, 4'd12, 1'b0});
    @(posedge clk);            // simultaneous push and pop
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("pp_ready_after", req_ready, 1'b1);
    @(posedge clk);
    #1;
    send(OP_DIV, 32'h4120_0000, 32'h4000_0000, 4'd13, 32'h40A0_0000, 1'b0, 1'b1);
    @(negedge clk);
    chk("pp_full_after_one_more", req_ready, 1'b0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain();

    // watchdog: FPU never signals done
    lat_cfg  = 2;
    hang_cfg = 1'b1;
    send(OP_MUL, 32'h4000_0000, 32'h4040_0000, 4'd7, 32'h7FC0_0000, 1'b1, 1'b1);
    drain();
    chk("timeout_start_to_rsp", rsp_cyc - start_cyc, TIMEOUT + 1);
    hang_cfg = 1'b0;
    send(OP_ADD, 32'h4000_0000, 32'h4000_0000, 4'd8, 32'h4080_0000, 1'b0, 1'b1);
    drain();

    // reset while waiting on the FPU
    lat_cfg = 10;
    s0 = start_cnt;
    send(OP_SUB, 32'h4040_0000, 32'h3F80_0000, 4'd3, 32'h0, 1'b0, 1'b0);
    n = 0;
    while (start_cnt == s0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_started", start_cnt - s0, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_in_wait_outputs");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // reset while holding a response
    lat_cfg   = 1;
    rsp_ready = 1'b0;
    send(OP_ADD, 32'h3F80_0000, 32'h4000_0000, 4'd4, 32'h0, 1'b0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached", rsp_valid, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_in_hold_outputs");
    @(posedge clk);
    #1;
    reset     = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    send(OP_SUB, 32'h4040_0000, 32'h3F80_0000, 4'd2, 32'h4000_0000, 1'b0, 1'b1);
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
